// File: rtl/icache_if.sv
// Fetch-side and backing-memory signals of the instruction cache.
// slave: the cache's own view. master: the PC stage and memory model.
interface icache_if #(
    parameter int LINE_BITS = 256
);
    logic                 req_i;
    logic [31:0]          addr_i;
    logic [31:0]          inst_o;
    logic                 stall_o;
    logic                 mem_enable_o;
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;

    modport slave (
        input  req_i, addr_i, mem_data_i, mem_ack_i,
        output inst_o, stall_o, mem_enable_o, mem_addr_o
    );

    modport master (
        output req_i, addr_i, mem_data_i, mem_ack_i,
        input  inst_o, stall_o, mem_enable_o, mem_addr_o
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with a zero-latency hit path
// and a single outstanding line refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | serving hits; a miss latches the line address
// MEM_REQ | line read held on the memory port until mem_ack_i
// REFILL  | one settling cycle after the line write, then back to IDLE
module icache_ctrl #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int OFF_W = 5;
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, MEM_REQ, REFILL} state_e;

    state_e               state_q, state_d;
    logic                 mem_enable_q, mem_enable_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic [IDX_W-1:0]     req_idx;
    logic [IDX_W-1:0]     fill_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [7:0]           word_lsb;
    logic                 hit;
    logic                 miss;
    logic                 fill_we;
    logic                 unused_bits;

    assign req_idx  = bus.addr_i[OFF_W +: IDX_W];
    assign req_tag  = bus.addr_i[31 -: TAG_W];
    assign word_lsb = {bus.addr_i[4:2], 5'b0};
    // The latched miss address doubles as the refill target.
    assign fill_idx = mem_addr_q[OFF_W +: IDX_W];

    assign hit  = bus.req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign miss = bus.req_i & ~hit;

    assign bus.inst_o       = hit ? data_q[req_idx][word_lsb +: 32] : 32'h0;
    assign bus.stall_o      = (state_q != IDLE) | miss;
    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_addr_o   = mem_addr_q;

    assign unused_bits = ^{bus.addr_i[1:0], mem_addr_q[4:0]};

    // Next-state and refill control; memory acks are only honoured in MEM_REQ.
    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_addr_d   = mem_addr_q;
        valid_d      = valid_q;
        fill_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d      = MEM_REQ;
                    mem_enable_d = 1'b1;
                    mem_addr_d   = {bus.addr_i[31:OFF_W], {OFF_W{1'b0}}};
                end
            end
            MEM_REQ: begin
                if (bus.mem_ack_i) begin
                    state_d           = REFILL;
                    mem_enable_d      = 1'b0;
                    mem_addr_d        = 32'h0;
                    valid_d[fill_idx] = 1'b1;
                    fill_we           = 1'b1;
                end
            end
            REFILL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and valid bits; reset abandons any refill in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_addr_q   <= 32'h0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_addr_q   <= mem_addr_d;
            valid_q      <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= mem_addr_q[31 -: TAG_W];
            data_q[fill_idx] <= bus.mem_data_i;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Only lookups made in IDLE count; stalled re-presentations do not.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == IDLE) begin
            if (hit)  hit_cnt_d  = hit_cnt_q + 32'd1;
            if (miss) miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Free-running wrap-around counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios followed by random fetches.
// The expected behaviour comes from a line-level cache model. Each slot
// remembers which memory line it holds, and memory contents are a fixed
// function of the line number.
module tb_icache_ctrl;
    localparam int NUM_LINES = 32;
    localparam int LINE_BITS = 256;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    icache_if #(.LINE_BITS(LINE_BITS)) bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_ctrl #(.NUM_LINES(NUM_LINES), .LINE_BITS(LINE_BITS)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    bit          m_valid [NUM_LINES];
    logic [31:0] m_line  [NUM_LINES];

    // Memory image: line 2 (byte address 0x40) carries the known words.
    function automatic logic [31:0] mem_word(input logic [31:0] line, input int w);
        if (line == 32'd2 && w == 0) return 32'h0000_0000;
        if (line == 32'd2 && w == 1) return 32'h1234_5678;
        return (line * 32'h9E37_79B1) ^ (32'(w) * 32'h0100_0193) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [LINE_BITS-1:0] mem_line(input logic [31:0] line);
        logic [LINE_BITS-1:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = mem_word(line, w);
        return r;
    endfunction

    function automatic logic [LINE_BITS-1:0] garbage();
        logic [LINE_BITS-1:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch, serviced until the model predicts a hit. The memory ack
    // arrives in the k-th MEM_REQ cycle. When sw is set, addr_i moves to alt
    // in the first MEM_REQ cycle.
    task automatic do_fetch(input logic [31:0] a, input int k, input bit sw, input logic [31:0] alt);
        logic [31:0] cur;
        logic [31:0] line;
        int          slot;
        bit          switched;
        cur      = a;
        switched = 1'b0;
        bus.req_i      = 1'b1;
        bus.addr_i     = cur;
        bus.mem_ack_i  = ($urandom_range(0, 3) == 0);
        bus.mem_data_i = garbage();
        for (int iter = 0; iter < 4; iter++) begin
            line = cur >> 5;
            slot = int'(line % NUM_LINES);
            @(negedge clk_i);
            if (m_valid[slot] && m_line[slot] == line) begin
                check("hit_stall", bus.stall_o, 32'd0);
                check("hit_inst", bus.inst_o, mem_word(line, int'(cur[4:2])));
                check("idle_mem_enable", bus.mem_enable_o, 32'd0);
                check("idle_mem_addr", bus.mem_addr_o, 32'd0);
                @(posedge clk_i); #1;
                bus.mem_ack_i = 1'b0;
                return;
            end
            check("miss_stall", bus.stall_o, 32'd1);
            check("miss_inst", bus.inst_o, 32'd0);
            check("miss_mem_enable", bus.mem_enable_o, 32'd0);
            @(posedge clk_i); #1;
            bus.mem_ack_i = 1'b0;
            for (int c = 1; c <= k; c++) begin
                if (sw && !switched) begin
                    cur        = alt;
                    bus.addr_i = alt;
                    switched   = 1'b1;
                end
                if (c == k) begin
                    bus.mem_ack_i  = 1'b1;
                    bus.mem_data_i = mem_line(line);
                end
                @(negedge clk_i);
                check("memreq_enable", bus.mem_enable_o, 32'd1);
                check("memreq_addr", bus.mem_addr_o, line << 5);
                check("memreq_stall", bus.stall_o, 32'd1);
                @(posedge clk_i); #1;
                bus.mem_ack_i  = 1'b0;
                bus.mem_data_i = garbage();
            end
            m_valid[slot] = 1'b1;
            m_line[slot]  = line;
            bus.mem_ack_i = $urandom_range(0, 1) == 1;
            @(negedge clk_i);
            check("refill_stall", bus.stall_o, 32'd1);
            check("refill_mem_enable", bus.mem_enable_o, 32'd0);
            check("refill_mem_addr", bus.mem_addr_o, 32'd0);
            @(posedge clk_i); #1;
            bus.mem_ack_i = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        bus.req_i      = 1'b0;
        bus.addr_i     = $urandom();
        bus.mem_ack_i  = $urandom_range(0, 1) == 1;
        bus.mem_data_i = garbage();
        @(negedge clk_i);
        check("noreq_stall", bus.stall_o, 32'd0);
        check("noreq_inst", bus.inst_o, 32'd0);
        check("noreq_mem_enable", bus.mem_enable_o, 32'd0);
        @(posedge clk_i); #1;
        bus.mem_ack_i = 1'b0;
    endtask

    initial begin
        logic [31:0] line;
        bus.req_i      = 1'b0;
        bus.addr_i     = 32'h0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        model_flush();

        // Reset values
        #2;
        check("rst_stall", bus.stall_o, 32'd0);
        check("rst_inst", bus.inst_o, 32'd0);
        check("rst_mem_enable", bus.mem_enable_o, 32'd0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Cold miss on 0x40 with the ack in the third MEM_REQ cycle
        do_fetch(32'h0000_0040, 3, 1'b0, 32'h0);

        // Hit streak across the whole line
        for (int w = 0; w < 8; w++) do_fetch(32'h40 + 32'(4 * w), 1, 1'b0, 32'h0);

`ifdef ICACHE_STATS_EN
        check("stats_miss", miss_cnt, 32'd1);
        check("stats_hit", hit_cnt, 32'd9);
`endif

        // Conflict eviction on the same index
        do_fetch(32'h0000_0440, 2, 1'b0, 32'h0);
        do_fetch(32'h0000_0040, 2, 1'b0, 32'h0);

        // Address change during MEM_REQ keeps the refill target
        do_fetch(32'h0000_0080, 3, 1'b1, 32'h0000_0100);

        // Reset in MEM_REQ, then a late ack
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_0C00;
        @(negedge clk_i);
        check("pre_rst_stall", bus.stall_o, 32'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("pre_rst_memreq", bus.mem_enable_o, 32'd1);
        #1;
        rst_i     = 1'b0;
        bus.req_i = 1'b0;
        #1;
        check("midrst_stall", bus.stall_o, 32'd0);
        check("midrst_mem_enable", bus.mem_enable_o, 32'd0);
        check("midrst_mem_addr", bus.mem_addr_o, 32'd0);
        check("midrst_inst", bus.inst_o, 32'd0);
        model_flush();
        @(posedge clk_i); #1;
        rst_i          = 1'b1;
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = mem_line(32'h0000_0C00 >> 5);
        @(negedge clk_i);
        check("late_ack_mem_enable", bus.mem_enable_o, 32'd0);
        @(posedge clk_i); #1;
        bus.mem_ack_i = 1'b0;
        do_fetch(32'h0000_0C00, 2, 1'b0, 32'h0);
        do_fetch(32'h0000_0040, 1, 1'b0, 32'h0);

        // Random fetches over a pool that aliases onto the 32 indices
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                line = 32'($urandom_range(0, 95));
                if ($urandom_range(0, 3) == 0) line = line | 32'h0400_0000;
                do_fetch((line << 5) | ($urandom() & 32'h1F), $urandom_range(1, 4),
                         $urandom_range(0, 7) == 0, ($urandom_range(0, 95) << 5) | ($urandom() & 32'h1F));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
